// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div with a fixed
// busy latency, and applies mthi/mtlo immediately.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_mdOp,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cancel,
  input  logic        i_hiLoSel,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pendHi;
  logic [31:0] r_pendLo;
  logic        r_pendValid;

  logic        w_busy;
  logic        w_loadMul;
  logic        w_loadDiv;
  logic        w_writeHi;
  logic        w_writeLo;
  logic        w_finish;

  logic [63:0] w_mulSigned;
  logic [63:0] w_mulUnsigned;
  logic [63:0] w_mulProd;

  logic        w_divSigned;
  logic        w_aNeg;
  logic        w_bNeg;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_divisorSafe;
  logic [31:0] w_quotMag;
  logic [31:0] w_remMag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Result is formed from the live operands at acceptance and parked in the pending registers.
  assign w_mulSigned   = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_mulUnsigned = {32'd0, i_a} * {32'd0, i_b};
  assign w_mulProd     = (i_mdOp == OP_MULT) ? w_mulSigned : w_mulUnsigned;

  // Signed divide works on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_divSigned   = (i_mdOp == OP_DIV);
  assign w_aNeg        = w_divSigned & i_a[31];
  assign w_bNeg        = w_divSigned & i_b[31];
  assign w_dividend    = w_aNeg ? (~i_a + 32'd1) : i_a;
  assign w_divisor     = w_bNeg ? (~i_b + 32'd1) : i_b;
  assign w_divisorSafe = (w_divisor == 32'd0) ? 32'd1 : w_divisor;
  assign w_quotMag     = w_dividend / w_divisorSafe;
  assign w_remMag      = w_dividend % w_divisorSafe;
  assign w_quot        = (w_aNeg ^ w_bNeg) ? (~w_quotMag + 32'd1) : w_quotMag;
  assign w_rem         = w_aNeg ? (~w_remMag + 32'd1) : w_remMag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_loadMul   = 1'b0;
    w_loadDiv   = 1'b0;
    w_writeHi   = 1'b0;
    w_writeLo   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_cancel) begin
          case (i_mdOp)
            OP_MULT, OP_MULTU: begin
              w_nextState = MUL;
              w_loadMul   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              w_nextState = DIV;
              w_loadDiv   = 1'b1;
            end
            OP_MTHI: w_writeHi = 1'b1;
            OP_MTLO: w_writeLo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        w_busy = 1'b1;
        if (r_count <= 4'd1) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= 4'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pendHi    <= 32'd0;
      r_pendLo    <= 32'd0;
      r_pendValid <= 1'b0;
    end else begin
      if (w_loadMul) begin
        r_count     <= MULT_LOAD;
        r_pendHi    <= w_mulProd[63:32];
        r_pendLo    <= w_mulProd[31:0];
        r_pendValid <= 1'b1;
      end else if (w_loadDiv) begin
        r_count     <= DIV_LOAD;
        r_pendHi    <= w_rem;
        r_pendLo    <= w_quot;
        r_pendValid <= (i_b != 32'd0);
      end else if (w_busy) begin
        r_count <= r_count - 4'd1;
      end

      // Divide by zero still burns its cycles but leaves HI/LO untouched.
      if (w_finish && r_pendValid) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
      if (w_writeHi) begin
        r_hi <= i_a;
      end
      if (w_writeLo) begin
        r_lo <= i_a;
      end
    end
  end

  assign o_busy = w_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_out  = i_hiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed mult/div/mthi/mtlo results,
// busy latency, cancel, busy-ignore, back-to-back and async reset behaviour.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        hiLoSel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  int nBusy;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_mdOp   (mdOp),
    .i_a      (a),
    .i_b      (b),
    .i_cancel (cancel),
    .i_hiLoSel(hiLoSel),
    .o_busy   (busy),
    .o_hi     (hi),
    .o_lo     (lo),
    .o_out    (out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the command is seen by the next posedge, then operands are scrambled.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] opA, input logic [31:0] opB,
                               input logic cxl);
    start  = 1'b1;
    mdOp   = op;
    a      = opA;
    b      = opB;
    cancel = cxl;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    mdOp   = OP_MULT;
    a      = 32'hDEAD_BEEF;
    b      = 32'h0BAD_F00D;
    @(negedge clk);
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_out", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
    checkOutput("mthi_hi", hi, 32'h11);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
    checkOutput("mtlo_lo", lo, 32'h22);
    hiLoSel = 1'b0;
    #1 checkOutput("out_lo", out, 32'h22);
    hiLoSel = 1'b1;
    #1 checkOutput("out_hi", out, 32'h11);
    hiLoSel = 1'b0;

    applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b0);
    waitIdle(nBusy);
    checkOutput("div0_cycles", 32'(nBusy), 32'd10);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);

    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkOutput("mult_busy", {31'd0, busy}, 32'd1);
    checkOutput("mult_out_old", out, 32'h22);
    waitIdle(nBusy);
    checkOutput("mult_cycles", 32'(nBusy), 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitIdle(nBusy);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0);
    waitIdle(nBusy);
    checkOutput("divu_cycles", 32'(nBusy), 32'd10);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    waitIdle(nBusy);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    waitIdle(nBusy);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'h0);

    applyStimulus(OP_MULT, 32'd5, 32'd5, 1'b1);
    checkOutput("cancel_busy", {31'd0, busy}, 32'd0);
    checkOutput("cancel_hi", hi, 32'h0);
    checkOutput("cancel_lo", lo, 32'h8000_0000);

    applyStimulus(OP_MULT, 32'd7, 32'd6, 1'b0);
    applyStimulus(OP_MTHI, 32'hABCD, 32'd0, 1'b0);
    checkOutput("ign_busy", {31'd0, busy}, 32'd1);
    checkOutput("ign_hi_during", hi, 32'h0);
    waitIdle(nBusy);
    checkOutput("ign_remaining", 32'(nBusy), 32'd4);
    checkOutput("ign_lo", lo, 32'd42);
    checkOutput("ign_hi", hi, 32'd0);

    applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
    waitIdle(nBusy);
    checkOutput("b2b_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("b2b_out_new", out, 32'd12);
    applyStimulus(OP_DIVU, 32'd9, 32'd2, 1'b0);
    checkOutput("b2b_busy_rise", {31'd0, busy}, 32'd1);
    waitIdle(nBusy);
    checkOutput("b2b_cycles", 32'(nBusy), 32'd10);
    checkOutput("b2b_lo", lo, 32'd4);
    checkOutput("b2b_hi", hi, 32'd1);

    applyStimulus(OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_hi", hi, 32'd0);
    checkOutput("rstmid_lo", lo, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_MTLO, 32'h5, 32'd0, 1'b0);
    checkOutput("rstmid_mtlo", lo, 32'h5);
    checkOutput("rstmid_hi_after", hi, 32'd0);
    checkOutput("rstmid_busy_after", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage pipeline, operating in parallel with the ALU. Accepts operands from the DE pipeline register, after forwarding, and runs mult/multu/div/divu over a fixed multi-cycle latency while asserting Busy. It owns the architectural HI/LO registers, handles mthi/mtlo, and drives the HI/LO value that mfhi/mflo carry into the EM pipeline register. Hazard control uses Busy to stall the FD/DE registers.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10: busy cycles for div/divu (1..15)

- Clock  input  1  single clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low; Reset==0 clears all state immediately
- Start  input  1  E-stage instruction is an md-class op this cycle (qualified by MDOp)
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved (treated as none)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Cancel  input  1  E-stage instruction is being flushed (exception/interrupt this cycle)
- HiLoSel  input  1  0 selects LO, 1 selects HI onto Out
- Busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- Out  output  32  HiLoSel ? HI : LO, combinational

## Operation
- Accepted command: Start=1, Cancel=0, Busy=0, MDOp in 1..6.
- Start=1 with Cancel=1 is discarded entirely: no state change, no Busy.
- Start=1 while Busy=1 is a hazard-unit violation. It is ignored, and the in-flight operation is unaffected.
- MDOp 0 or 7 with Start=1 is ignored.
- mthi/mtlo: HI<=A (resp. LO<=A) at the accepting edge. Busy stays 0.
- mult: signed 32x32, {HI,LO} = 64-bit product. multu: unsigned.
- div: signed. LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0): operation still takes DIV_CYCLES with Busy asserted, and HI/LO keep their prior values.
- Signed overflow 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Operands are latched at the accepting edge. Later changes to A/B/MDOp do not affect the result.
- State machine:
  - IDLE -> MUL on an accepted mult/multu; IDLE -> DIV on an accepted div/divu. The 4-bit counter loads MULT_CYCLES or DIV_CYCLES.
  - MUL/DIV: counter decrements each cycle. When the counter reaches 1, HI/LO are written at that edge and the state returns to IDLE.
- Implementation may compute the result combinationally at acceptance and hold it in pending registers, or iterate. Only the timing below is normative.
- Once accepted, an operation cannot be cancelled; Cancel affects only the same-cycle command.
- HI/LO are not visible as updated until the operation completes. Out during Busy shows the old HI/LO, and the hazard unit stalls mfhi/mflo while Busy=1.

## Timing
- Reset (Reset==0, async): HI=0, LO=0, Busy=0, state IDLE, counter 0, pending result cleared. Out=0.
- Reset asserted mid-operation aborts it. After release the unit is IDLE and the next edge may accept a command.
- Accept at edge t (mult): Busy=1 during cycles t+1..t+MULT_CYCLES. HI/LO take the new values at the edge ending cycle t+MULT_CYCLES. Busy=0 from that same edge.
- div/divu behave the same way with DIV_CYCLES.
- A back-to-back command may be accepted in the first cycle Busy=0. There are no dead cycles.
- mthi/mtlo: HI/LO update at the accepting edge and are visible on Out in the next cycle. Latency is 1 and Busy is never raised.
- Out is combinational from HI/LO/HiLoSel, with zero latency.

## Test plan
- Reset mid-operation: div accepted, Reset low 3 cycles later -> Busy=0, HI=LO=0 immediately (async). After release, mtlo A=0x5 -> LO=0x5 next cycle.
- Signed mult: A=0xFFFFFFFE (-2), B=0x3, MULT_CYCLES=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Out shows the old LO while Busy.
- multu and divu:
  - multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - divu A=100, B=7 -> LO=14, HI=2 after 10 Busy cycles.
- Signed div and div-by-zero:
  - div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div B=0 with prior HI=0x11, LO=0x22 -> Busy 10 cycles, then HI=0x11, LO=0x22.
- Cancel and busy interaction:
  - Start mult with Cancel=1 -> Busy stays 0, HI/LO unchanged.
  - mthi A=0xABCD while Busy -> ignored, and the in-flight result lands unchanged.
- Back-to-back: mult completes, mflo selected (HiLoSel=0) the same cycle Busy drops -> Out = new LO. A divu accepted in that cycle -> Busy rises at the next edge with no gap.
